// File: rtl/minos_ram_pkg.sv
// Shared parameters and FSM state encoding for the 2048x8 RAM unit and its stream reader.
package minos_ram_pkg;
  localparam int RAM_ADDR_W = 11;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_LEN_W  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;
endpackage

// File: rtl/ram_rd_fifo.sv
// Two-entry FIFO for read-return data; zero-latency head on pop_data.
// Push is dropped only when full with no pop; push and pop together on full keep count unchanged.
module ram_rd_fifo
  import minos_ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        cnt;
  logic              do_push;
  logic              do_pop;

  assign empty    = (cnt == 2'd0);
  assign full     = (cnt == 2'd2);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // On full, a same-cycle pop frees the slot the push is about to overwrite.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= !wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= !rd_ptr;
      end
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a RAM address range on port B and streams the bytes out valid/ready, one per cycle
// when unstalled; first byte 3 cycles after START, issue throttled by buffer credit under backpressure.
module ram_stream_reader
  import minos_ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int LEN_W  = RAM_LEN_W
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              START,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [LEN_W-1:0]  LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ENB,
  output logic              WEB,
  output logic [ADDR_W-1:0] ADDRB,
  output logic [DATA_W-1:0] DINB,
  input  logic [DATA_W-1:0] DOUTB,
  output logic              M_VALID,
  output logic [DATA_W-1:0] M_DATA,
  input  logic              M_READY
);

  rd_state_e         state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addrb_q;
  logic [LEN_W-1:0]  remaining;
  logic              inflight;
  logic              busy_q;
  logic              done_q;
  logic              issue;
  logic              pop;
  logic              drained;
  logic [1:0]        fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  assign M_VALID = !fifo_empty;
  assign pop     = M_VALID && M_READY;

  // Occupancy after this cycle's return and pop must leave room for the read issued now.
  assign issue = (state == RUN) && (remaining != '0) &&
                 (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign drained = !inflight && (fifo_count == {1'b0, pop});

  assign ENB   = issue;
  assign ADDRB = issue ? addr : addrb_q;
  assign WEB   = 1'b0;
  assign DINB  = '0;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

  ram_rd_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .push      (inflight),
    .push_data (DOUTB),
    .pop       (pop),
    .pop_data  (M_DATA),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      addr      <= '0;
      addrb_q   <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      inflight <= issue;
      done_q   <= 1'b0;
      if (issue) begin
        addr      <= addr + 1'b1;
        addrb_q   <= addr;
        remaining <= remaining - 1'b1;
      end
      case (state)
        IDLE: begin
          if (START) begin
            if (LEN == '0) begin
              done_q <= 1'b1;
            end else begin
              addr      <= START_ADDR;
              remaining <= LEN;
              busy_q    <= 1'b1;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (issue && (remaining == LEN_W'(1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // DONE is raised once the final byte leaves; BUSY drops the cycle after.
          if (done_q) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (drained) begin
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A return arriving into a full buffer with no pop would be lost.
  assert property (@(posedge CLK) disable iff (!RSTn) !(inflight && fifo_full && !pop));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural 2048x8 port-B RAM and a byte scoreboard.
module tb_ram_stream_reader;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        START = 1'b0;
  logic [10:0] START_ADDR = '0;
  logic [11:0] LEN = '0;
  logic        BUSY, DONE, ENB, WEB;
  logic [10:0] ADDRB;
  logic [7:0]  DINB, DOUTB, M_DATA;
  logic        M_VALID;
  logic        M_READY = 1'b1;

  logic [7:0]  mem [2048];

  ram_stream_reader dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .START      (START),
    .START_ADDR (START_ADDR),
    .LEN        (LEN),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ENB        (ENB),
    .WEB        (WEB),
    .ADDRB      (ADDRB),
    .DINB       (DINB),
    .DOUTB      (DOUTB),
    .M_VALID    (M_VALID),
    .M_DATA     (M_DATA),
    .M_READY    (M_READY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ENB) DOUTB <= mem[ADDRB];
  end

  int          nchk = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  logic [7:0]  exp_q [$];
  logic [10:0] exp_addr_q [$];
  int          outstanding, pop_cnt, enb_cnt, done_cnt, done_cyc;
  int          first_pop, last_pop, busy_first, busy_fall;
  logic        stalled_prev, valid_seen;
  logic [7:0]  prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic       pop;
    logic [7:0] e;
    pop = M_VALID && M_READY;
    if (stalled_prev) begin
      chk("valid_hold", M_VALID, 1);
      chk("data_hold", M_DATA, prev_data);
    end
    if (M_VALID) valid_seen = 1'b1;
    if (pop) begin
      if (exp_q.size() == 0) begin
        chk("extra_byte", M_VALID, 0);
      end else begin
        e = exp_q.pop_front();
        chk("byte", M_DATA, e);
      end
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      pop_cnt++;
    end
    if (ENB) begin
      chk("credit", (outstanding - int'(pop) < 2), 1);
      if (exp_addr_q.size() == 0) chk("extra_issue", ENB, 0);
      else chk("addrb", ADDRB, exp_addr_q.pop_front());
      outstanding++;
      enb_cnt++;
    end
    if (pop) outstanding--;
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (BUSY && busy_first < 0) busy_first = cyc;
    if (!BUSY && busy_first >= 0 && busy_fall < 0) busy_fall = cyc;
    stalled_prev = M_VALID && !M_READY;
    prev_data = M_DATA;
  endtask

  task automatic tick();
    @(posedge CLK);
    cyc++;
    #1;
    M_READY = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 1);
    @(negedge CLK);
    monitor();
  endtask

  task automatic start_xfer(input logic [10:0] a, input logic [11:0] n, input int mode);
    logic [10:0] ad;
    outstanding = 0; pop_cnt = 0; enb_cnt = 0; done_cnt = 0; done_cyc = -1;
    first_pop = -1; last_pop = -1; busy_first = -1; busy_fall = -1;
    stalled_prev = 1'b0; valid_seen = 1'b0;
    rdy_mode = mode;
    for (int i = 0; i < int'(n); i++) begin
      ad = a + 11'(i);
      exp_addr_q.push_back(ad);
      exp_q.push_back(ad[7:0]);
    end
    START_ADDR = a; LEN = n; START = 1'b1; cyc = 0;
    tick();
    START = 1'b0;
  endtask

  task automatic run(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0 && cyc >= done_cyc + 2) break;
      tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_enb"}, ENB, 0);
    chk({tag, "_web"}, WEB, 0);
    chk({tag, "_addrb"}, ADDRB, 0);
    chk({tag, "_dinb"}, DINB, 0);
    chk({tag, "_mvalid"}, M_VALID, 0);
    chk({tag, "_mdata"}, M_DATA, 0);
  endtask

  task automatic check_end(input string tag, input int nbytes);
    chk({tag, "_bytes"}, pop_cnt, nbytes);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_q_left"}, exp_q.size(), 0);
    chk({tag, "_addr_left"}, exp_addr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 8'(a);

    // reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("rst");
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    // basic 4-byte transfer, ready held high
    start_xfer(11'h010, 12'd4, 0);
    run(40);
    check_end("t1", 4);
    chk("t1_busy_first", busy_first, 1);
    chk("t1_first_byte_cyc", first_pop, 3);
    chk("t1_last_byte_cyc", last_pop, 6);
    chk("t1_done_cyc", done_cyc, 7);
    chk("t1_busy_fall", busy_fall, 8);

    // same transfer with M_READY toggling 1,0,0
    start_xfer(11'h010, 12'd4, 1);
    run(60);
    check_end("t2", 4);

    // address wrap at top of RAM
    start_xfer(11'h7FE, 12'd4, 0);
    run(40);
    check_end("t3", 4);
    chk("t3_done_cyc", done_cyc, 7);

    // zero-length command
    start_xfer(11'h123, 12'd0, 0);
    repeat (4) tick();
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_done_cyc", done_cyc, 1);
    chk("t4_enb_cnt", enb_cnt, 0);
    chk("t4_valid_seen", valid_seen, 0);
    chk("t4_busy_seen", busy_first, -1);

    // second START while busy is ignored
    start_xfer(11'h100, 12'd8, 0);
    tick();
    START_ADDR = 11'h300; LEN = 12'd3; START = 1'b1;
    tick();
    START = 1'b0;
    run(60);
    check_end("t5", 8);

    // reset mid-transfer, then a fresh short transfer
    start_xfer(11'h040, 12'd16, 0);
    for (int i = 0; i < 30 && pop_cnt < 3; i++) tick();
    chk("t6_pre_bytes", pop_cnt, 3);
    RSTn = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    start_xfer(11'h020, 12'd2, 0);
    run(40);
    check_end("t6", 2);
    chk("t6_done_cyc", done_cyc, 5);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side initiator for the 2048×8 dual-port RAM unit. On a START command it walks a contiguous address range on the RAM's port B (read-only use) and emits each byte on a valid/ready byte stream. A 2-entry output buffer absorbs the RAM's one-cycle registered-address read latency, so the stream runs at one byte per cycle when unstalled. It sits between the RAM unit and any byte consumer (UART TX, bus bridge, display path).

## Interface
- ADDR_W, default 11: RAM address width.
- DATA_W, default 8: RAM data width.
- LEN_W, default 12: transfer length width; values 0..2048 are legal.
- CLK  in  1  clock; all state on rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- START  in  1  command strobe; sampled only in IDLE.
- START_ADDR  in  ADDR_W  first byte address.
- LEN  in  LEN_W  byte count.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse after the last byte handshakes.
- ENB  out  1  RAM port-B enable; high only in issue cycles.
- WEB  out  1  tied 0.
- ADDRB  out  ADDR_W  RAM port-B address.
- DINB  out  DATA_W  tied 0.
- DOUTB  in  DATA_W  RAM read data; valid the cycle after the address is presented.
- M_VALID  out  1  stream data valid.
- M_DATA  out  DATA_W  stream byte.
- M_READY  in  1  consumer ready; a byte transfers when M_VALID & M_READY.

## Operation
- FSM: IDLE → RUN → DRAIN → IDLE.
- IDLE: START=1 with LEN≠0 latches addr=START_ADDR, remaining=LEN, and goes to RUN. START with LEN=0 pulses DONE next cycle, stays IDLE, issues no reads.
- RUN: issue a read (ENB=1, ADDRB=addr) when remaining>0 and occupancy + inflight − pop < 2. On issue, addr increments modulo 2^ADDR_W (0x7FF → 0x000) and remaining decrements. RUN → DRAIN when the last read issues.
- inflight (0/1) = read issued in the previous cycle. DOUTB is pushed into the buffer in the cycle it is valid.
- DRAIN: no issues. Leaves to IDLE when inflight=0, buffer empty and the last byte has handshaken. DONE pulses that cycle.
- Buffer is FIFO order. M_DATA is the head entry and is held stable while M_VALID & !M_READY. M_VALID never drops without a handshake.
- START while BUSY is ignored; it has no effect on state or outputs.
- Reset at any time (async assert) returns to IDLE. It clears the counters, buffer and inflight. Reads that have not yet returned are discarded.
- Reset values: BUSY=0, DONE=0, ENB=0, WEB=0, ADDRB=0, DINB=0, M_VALID=0, M_DATA=0.

## Timing
- START sampled high at edge 0: BUSY=1 and first ENB in cycle 1. DOUTB valid in cycle 2, captured at edge 3, M_VALID=1 in cycle 3.
- With M_READY held high: one byte per cycle. The last byte of an N-byte transfer is in cycle N+2, and DONE is in cycle N+3.
- Backpressure: issuing stalls within one cycle of the buffer filling. No byte is dropped or duplicated. Both buffer entries may fill because of the in-flight read.
- Simultaneous push and pop on a full buffer is legal; occupancy is unchanged.
- ADDRB holds its last value when ENB=0.

## Structure
- Shared package minos_ram_pkg: RAM_ADDR_W=11, RAM_DATA_W=8, RAM_LEN_W=12, and the FSM state enum (IDLE, RUN, DRAIN).
- Sub-module ram_rd_fifo: 2-entry synchronous FIFO with push, pop, full, empty and count. Its async active-low reset uses the same CLK and RSTn.
- Top level holds the FSM, address and remaining counters, the inflight flag, and the issue-credit logic.

## Test plan
- Memory preloaded with mem[a] = a[7:0]; START_ADDR=0x010, LEN=4, M_READY=1 → bytes 0x10,0x11,0x12,0x13 on consecutive cycles 3..6; DONE in cycle 7; BUSY low in cycle 8.
- Same transfer with M_READY toggling 1,0,0,1,… → identical byte order; M_DATA stable while stalled; ENB never issues with the buffer full and a read in flight.
- START_ADDR=0x7FE, LEN=4 → ADDRB sequence 0x7FE,0x7FF,0x000,0x001; data 0xFE,0xFF,0x00,0x01.
- LEN=0 → DONE pulse in cycle 1; ENB and M_VALID stay 0; BUSY stays 0.
- Second START pulsed in cycle 2 of a LEN=8 run → ignored; exactly 8 bytes; one DONE.
- RSTn asserted after 3 of LEN=16 bytes, then released → all outputs at reset values immediately; a new LEN=2 transfer afterwards yields only its own 2 bytes.
